// File: rtl/sobel_pkg.sv
// Shared constants for the parametrised Sobel edge filter:
// output mode encodings, window tap indices and gradient width.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_GX      = 2'd0,
    MODE_GY      = 2'd1,
    MODE_ABS_SUM = 2'd2,
    MODE_THRESH  = 2'd3
  } mode_e;

  localparam int TAP_UL = 0;
  localparam int TAP_U  = 1;
  localparam int TAP_UR = 2;
  localparam int TAP_L  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_R  = 5;
  localparam int TAP_DL = 6;
  localparam int TAP_D  = 7;
  localparam int TAP_DR = 8;

  function automatic int grad_w(input int ch_w);
    return ch_w + 4;
  endfunction

endpackage

// File: rtl/sobel_channel_kernel.sv
// One colour channel: registered Gx/Gy (S2) and the
// combinational mode select / clamp / threshold feeding S3.
module sobel_channel_kernel
  import sobel_pkg::*;
#(
  parameter int CH_W      = 4,
  parameter int OUT_SHIFT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [9*CH_W-1:0]   i_taps,
  input  mode_e               i_mode,
  input  logic [CH_W+3:0]     i_thr,
  output logic [CH_W-1:0]     o_res
);

  localparam int GW = grad_w(CH_W);
  localparam logic [GW-1:0] LIM =
    GW'((1 << (CH_W + OUT_SHIFT)) - 1);

  logic signed [GW-1:0] w_t [9];
  logic signed [GW-1:0] w_gx, w_gy;
  logic signed [GW-1:0] r_gx, r_gy;
  logic [GW-1:0] w_ax, w_ay, w_sum;
  logic [GW-1:0] w_r, w_cl, w_sh;

  for (genvar k = 0; k < 9; k++) begin : g_tap
    assign w_t[k] =
      signed'({{(GW-CH_W){1'b0}}, i_taps[k*CH_W +: CH_W]});
  end

  assign w_gx = w_t[TAP_UR] - w_t[TAP_UL]
              + ((w_t[TAP_R] - w_t[TAP_L]) <<< 1)
              + w_t[TAP_DR] - w_t[TAP_DL];
  assign w_gy = w_t[TAP_DL] - w_t[TAP_UL]
              + ((w_t[TAP_D] - w_t[TAP_U]) <<< 1)
              + w_t[TAP_DR] - w_t[TAP_UR];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gx <= '0;
      r_gy <= '0;
    end else if (en) begin
      r_gx <= w_gx;
      r_gy <= w_gy;
    end
  end

  // Sum of magnitudes never exceeds 8*(2^CH_W-1), so GW bits suffice
  assign w_ax  = r_gx[GW-1] ? GW'(-r_gx) : r_gx;
  assign w_ay  = r_gy[GW-1] ? GW'(-r_gy) : r_gy;
  assign w_sum = w_ax + w_ay;

  always_comb begin
    w_r = '0;
    unique case (i_mode)
      MODE_GX:      w_r = r_gx[GW-1] ? '0 : r_gx;
      MODE_GY:      w_r = r_gy[GW-1] ? '0 : r_gy;
      MODE_ABS_SUM: w_r = w_sum;
      MODE_THRESH:  w_r = '0;
    endcase
    w_cl  = (w_r > LIM) ? LIM : w_r;
    w_sh  = w_cl >> OUT_SHIFT;
    o_res = (i_mode == MODE_THRESH) ?
            {CH_W{w_sum >= i_thr}} : w_sh[CH_W-1:0];
  end

endmodule

// File: rtl/sobel_edge_detect_param_module.sv
// 3-stage valid-tagged Sobel filter: S1 input regs, S2 gradients,
// S3 per-mode result. Mode/threshold/center travel with the pixel.
module sobel_edge_detect_param_module
  import sobel_pkg::*;
#(
  parameter int CH_W      = 4,
  parameter int CHANNELS  = 3,
  parameter int OUT_SHIFT = 2,
  parameter int PIX_W     = CHANNELS * CH_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [1:0]           mode,
  input  logic [CH_W+3:0]      threshold,
  input  logic [9*PIX_W-1:0]   window_data,
  output logic                 out_valid,
  output logic [PIX_W-1:0]     filter_rgb_out,
  output logic [PIX_W-1:0]     original_out
);

  logic                 r_v1, r_v2, r_v3;
  logic [9*PIX_W-1:0]   r_win;
  mode_e                r_mode1, r_mode2;
  logic [CH_W+3:0]      r_thr1, r_thr2;
  logic [PIX_W-1:0]     r_c2, r_c3, r_res;
  logic [PIX_W-1:0]     w_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_win   <= '0;
      r_mode1 <= MODE_GX;
      r_mode2 <= MODE_GX;
      r_thr1  <= '0;
      r_thr2  <= '0;
      r_c2    <= '0;
      r_c3    <= '0;
      r_res   <= '0;
    end else if (en) begin
      r_v1    <= in_valid;
      r_win   <= window_data;
      r_mode1 <= mode_e'(mode);
      r_thr1  <= threshold;
      r_v2    <= r_v1;
      r_mode2 <= r_mode1;
      r_thr2  <= r_thr1;
      r_c2    <= r_win[TAP_C*PIX_W +: PIX_W];
      r_v3    <= r_v2;
      r_c3    <= r_c2;
      r_res   <= r_v2 ? w_res : '0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [9*CH_W-1:0] w_taps;
    for (genvar k = 0; k < 9; k++) begin : g_tap
      assign w_taps[k*CH_W +: CH_W] =
        r_win[k*PIX_W + c*CH_W +: CH_W];
    end
    sobel_channel_kernel #(
      .CH_W      (CH_W),
      .OUT_SHIFT (OUT_SHIFT)
    ) u_kernel (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .i_taps (w_taps),
      .i_mode (r_mode2),
      .i_thr  (r_thr2),
      .o_res  (w_res[c*CH_W +: CH_W])
    );
  end

  assign out_valid      = r_v3;
  assign filter_rgb_out = r_res;
  assign original_out   = r_c3;

endmodule

// File: tb/tb_sobel_edge_detect_param_module.sv
// Bench for the Sobel filter: table vectors, stall/reset sequences
// and random traffic against an arithmetic reference model.
module tb_sobel_edge_detect_param_module;

  localparam int CH_W = 4;
  localparam int CHN  = 3;
  localparam int PW   = CHN * CH_W;
  localparam int WW   = 9 * PW;

  logic          clk = 1'b0;
  logic          reset, en, in_valid;
  logic [1:0]    mode;
  logic [7:0]    threshold;
  logic [WW-1:0] window_data;
  logic          out_valid;
  logic [PW-1:0] filter_rgb_out, original_out;

  sobel_edge_detect_param_module #(
    .CH_W(CH_W), .CHANNELS(CHN), .OUT_SHIFT(2)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
    .mode(mode), .threshold(threshold),
    .window_data(window_data), .out_valid(out_valid),
    .filter_rgb_out(filter_rgb_out), .original_out(original_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] rgb;
    logic [PW-1:0] org;
    int            due;
  } exp_t;

  typedef struct {
    logic [WW-1:0] win;
    logic [1:0]    m;
    logic [7:0]    th;
    logic [PW-1:0] exp_rgb;
  } vec_t;

  exp_t q[$];
  exp_t cur;
  logic cur_v = 1'b0;
  int   en_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [WW-1:0] mkwin(
    input logic [PW-1:0] ul, u, ur, l, c, r, dl, d, dr);
    return {dr, d, dl, r, c, l, ur, u, ul};
  endfunction

  function automatic logic [PW-1:0] ref_out(
    input logic [WW-1:0] w, input logic [1:0] m,
    input logic [7:0] th);
    logic [PW-1:0] o;
    int t[9];
    int gx, gy, s, r;
    o = '0;
    for (int c = 0; c < CHN; c++) begin
      for (int k = 0; k < 9; k++)
        t[k] = int'(w[k*PW + c*CH_W +: CH_W]);
      gx = t[2] + 2*t[5] + t[8] - t[0] - 2*t[3] - t[6];
      gy = t[6] + 2*t[7] + t[8] - t[0] - 2*t[1] - t[2];
      s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (m == 2'd3) begin
        r = (s >= int'(th)) ? 15 : 0;
      end else begin
        if (m == 2'd0)      r = gx > 0 ? gx : 0;
        else if (m == 2'd1) r = gy > 0 ? gy : 0;
        else                r = s;
        if (r > 63) r = 63;
        r = r / 4;
      end
      o[c*CH_W +: CH_W] = 4'(r);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, req, $time);
    end
  endtask

  task automatic step(input logic v, input logic e,
                      input logic rst, input logic [WW-1:0] w,
                      input logic [1:0] m, input logic [7:0] th,
                      input logic ovr, input logic [PW-1:0] orgb);
    exp_t x;
    reset = rst; en = e; in_valid = v;
    window_data = w; mode = m; threshold = th;
    x.rgb = ovr ? orgb : ref_out(w, m, th);
    x.org = w[4*PW +: PW];
    x.due = en_cnt + 3;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      cur_v = 1'b0;
      chk("reset_orig", original_out, 0);
    end else if (e) begin
      if (v) q.push_back(x);
      en_cnt++;
      if (q.size() > 0 && q[0].due == en_cnt) begin
        cur   = q.pop_front();
        cur_v = 1'b1;
      end else begin
        cur_v = 1'b0;
      end
    end
    chk("out_valid", out_valid, cur_v);
    if (cur_v) begin
      chk("filter_rgb", filter_rgb_out, cur.rgb);
      chk("original", original_out, cur.org);
    end else begin
      chk("rgb_zero", filter_rgb_out, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, 1'b0, '0, 2'd0, 8'd0, 1'b0, '0);
  endtask

  task automatic px(input logic [WW-1:0] w, input logic [1:0] m);
    step(1'b1, 1'b1, 1'b0, w, m, 8'd0, 1'b0, '0);
  endtask

  vec_t vt[11];
  logic [WW-1:0] w1, w2, wf, wb, wr;

  initial begin
    w1 = mkwin(12'h000, 12'h888, 12'hFFF, 12'h000, 12'h888,
               12'hFFF, 12'h000, 12'h888, 12'hFFF);
    w2 = mkwin(12'hFFF, 12'h888, 12'h000, 12'hFFF, 12'h888,
               12'h000, 12'hFFF, 12'h888, 12'h000);
    wf = mkwin(12'h777, 12'h777, 12'h777, 12'h777, 12'h777,
               12'h777, 12'h777, 12'h777, 12'h777);
    wb = mkwin(12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0,
               12'h444, 12'h444, 12'h444);
    wr = mkwin(12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0,
               12'h400, 12'h400, 12'h400);
    vt[0]  = '{w1, 2'd0, 8'd0,  12'hFFF};
    vt[1]  = '{w2, 2'd0, 8'd0,  12'h000};
    vt[2]  = '{w2, 2'd2, 8'd0,  12'hFFF};
    vt[3]  = '{wf, 2'd1, 8'd0,  12'h000};
    vt[4]  = '{wb, 2'd1, 8'd0,  12'h444};
    vt[5]  = '{wr, 2'd1, 8'd0,  12'h400};
    vt[6]  = '{w1, 2'd3, 8'd60, 12'hFFF};
    vt[7]  = '{w1, 2'd3, 8'd61, 12'h000};
    vt[8]  = '{w1, 2'd0, 8'd0,  12'hFFF};
    vt[9]  = '{w1, 2'd3, 8'd60, 12'hFFF};
    vt[10] = '{w2, 2'd0, 8'd0,  12'h000};

    step(1'b1, 1'b1, 1'b1, w1, 2'd0, 8'd0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0, 2'd0, 8'd0, 1'b0, '0);
    idle(2);

    // single pixel: valid must appear on exactly the third cycle
    step(1'b1, 1'b1, 1'b0, w1, 2'd0, 8'd0, 1'b1, 12'hFFF);
    idle(4);

    // table vectors back to back, modes changing every pixel
    for (int i = 0; i < 11; i++)
      step(1'b1, 1'b1, 1'b0, vt[i].win, vt[i].m, vt[i].th,
           1'b1, vt[i].exp_rgb);
    idle(4);

    // five pixels with a four-cycle stall mid-stream
    px(w1, 2'd0);
    px(wb, 2'd1);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, w2, 2'd2, 8'd0, 1'b0, '0);
    px(w2, 2'd2);
    px(wr, 2'd1);
    px(w1, 2'd2);
    idle(5);

    // reset with three pixels in flight
    px(w1, 2'd0);
    px(w2, 2'd2);
    px(wb, 2'd1);
    step(1'b0, 1'b1, 1'b1, '0, 2'd0, 8'd0, 1'b0, '0);
    idle(5);
    px(w1, 2'd2);
    idle(4);

    // random traffic with stalls and rare resets
    for (int i = 0; i < 400; i++) begin
      logic [WW-1:0] rw;
      for (int k = 0; k < 9; k++)
        rw[k*PW +: PW] = 12'($urandom);
      step(1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 9) < 8),
           1'($urandom_range(0, 99) == 0),
           rw, 2'($urandom), 8'($urandom_range(0, 130)),
           1'b0, '0);
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
